reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Shares the single write port of the 32-bit register unit between two requesters: requester 0 (core write-back) and requester 1 (loader/debug port, which may lock the port for bursts). It arbitrates round-robin, handles a bounded burst lock for requester 1, and drops writes to x0. It drives the registered enable/address/data that feed the register unit's D_vector/en_reg inputs one cycle after each accepted request.

## Interface
- WIDTH, 32, data width of register unit
- ADDR_W, 5, register address width
- MAX_BURST, 4, max consecutive locked transfers for requester 1 while requester 0 waits (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- req0  in  1  requester 0 write request
- addr0  in  ADDR_W  requester 0 destination register
- data0  in  WIDTH  requester 0 write data
- gnt0  out  1  combinational grant; transfer when req0 & gnt0 at rising clk
- req1  in  1  requester 1 write request
- lock1  in  1  requester 1 asks to keep the port after this transfer
- addr1  in  ADDR_W  requester 1 destination register
- data1  in  WIDTH  requester 1 write data
- gnt1  out  1  combinational grant for requester 1
- en_reg  out  1  registered write enable to register unit
- wr_addr  out  ADDR_W  registered write address
- D_vector  out  WIDTH  registered write data
- owner  out  1  registered index of the last accepted requester

## Operation
- Internal state: mode ∈ {OPEN, LOCKED}, last (1 bit, last served), cnt (burst counter, 0..MAX_BURST, saturating).
- Grants are mutually exclusive; gnt_k never high unless req_k high.
- OPEN: only one req → grant it. Both req → grant the requester ≠ last.
- LOCKED: gnt0=0, gnt1=req1, unless cnt==MAX_BURST and req0=1; then gnt1=0, gnt0=1 (forced release).
- Transfer on edge when req_k & gnt_k: en_reg←(addr_k≠0), wr_addr←addr_k, D_vector←data_k, owner←k, last←k. No transfer: en_reg←0, wr_addr/D_vector/owner hold.
- Writes to address 0 complete the handshake (grant given) but en_reg stays 0.
- Transitions:
  - OPEN→LOCKED: requester 1 transfers with lock1=1; cnt←1.
  - LOCKED, requester 1 transfers with lock1=1: stay, cnt←min(cnt+1, MAX_BURST).
  - LOCKED, requester 1 transfers with lock1=0: →OPEN, cnt←0.
  - LOCKED, req1=0: →OPEN, cnt←0 (lock abandoned).
  - LOCKED, forced release (requester 0 transfers): →OPEN, cnt←0.
  - cnt saturates at MAX_BURST while req0=0; lock continues.
- Requesters hold req/addr/data stable until granted; the arbiter does not check this.

## Timing
- gnt0/gnt1 combinational from req0, req1, mode, last, cnt; no combinational path from addr/data to grants.
- Latency: request accepted at edge N → en_reg/wr_addr/D_vector valid during cycle N+1, written into the register unit at edge N+1.
- Throughput: one transfer per cycle, back-to-back allowed from either requester.
- Reset (rst_n=0 at edge): en_reg=0, wr_addr=0, D_vector=0, owner=0, mode=OPEN, cnt=0, last=1 (requester 0 wins first tie). While rst_n=0, gnt0=gnt1=0 and no transfer occurs. Reset mid-burst drops the lock; no partial write is emitted.
- Simultaneous req0 and lock release in the same cycle: release takes effect on that edge; next cycle is OPEN with last=1, so requester 0 wins a tie.

## Test plan
- Reset: hold rst_n=0 two cycles with req0=req1=1 → gnt0=gnt1=0, en_reg=0, wr_addr=0, D_vector=0, owner=0; release → first tie grants requester 0.
- Single write: req0, addr0=5, data0=0x0000000F at edge N → cycle N+1 en_reg=1, wr_addr=5, D_vector=0x0000000F, owner=0; next cycle en_reg=0.
- Round-robin: req0 and req1 held high for 4 cycles, no lock → grants 0,1,0,1; D_vector alternates data0/data1.
- x0 drop: req1, addr1=0, data1=0xFFFFFFFF → gnt1=1, en_reg stays 0, owner=1.
- Burst with starvation bound (MAX_BURST=4): req1=lock1=1 for 8 cycles, req0 raised at 2nd transfer → requester 1 gets 4 consecutive grants, then gnt0=1 for one transfer, mode returns to OPEN; next tie goes to requester 1.
- Reset mid-burst: assert rst_n=0 during 3rd locked transfer → no write next cycle, mode=OPEN, cnt=0; after release, tie grants requester 0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Shares the single write port of the register unit between requester 0
// (core write-back) and requester 1 (loader/debug, may lock for bursts).
// Round-robin between the two, bounded burst lock for requester 1, and
// writes to x0 complete the handshake but never raise en_reg.
module reg_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic              gnt1,
  output logic              en_reg,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  D_vector,
  output logic              owner
);

  localparam logic [0:0] MODE_OPEN   = 1'b0;
  localparam logic [0:0] MODE_LOCKED = 1'b1;

  // Counter must hold 0..MAX_BURST inclusive.
  localparam int              CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Arbitration state
  logic [0:0]       mode_q, mode_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // Registered write port towards the register unit
  logic              en_q,    en_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic              owner_q, owner_d;

  logic gnt0_s, gnt1_s;
  logic xfer0_s, xfer1_s;

  // Grant decode: depends only on requests and arbitration state, never on addr/data.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (mode_q)
        MODE_OPEN: begin
          if (req0 && req1) begin
            // Tie goes to whoever was not served last.
            gnt0_s = last_q;
            gnt1_s = ~last_q;
          end else begin
            gnt0_s = req0;
            gnt1_s = req1;
          end
        end
        MODE_LOCKED: begin
          if ((cnt_q == CNT_MAX) && req0) begin
            // Starvation bound reached: requester 0 breaks the lock.
            gnt0_s = 1'b1;
            gnt1_s = 1'b0;
          end else begin
            gnt0_s = 1'b0;
            gnt1_s = req1;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign xfer0_s = req0 & gnt0_s;
  assign xfer1_s = req1 & gnt1_s;

  // Next-state for the write port and the lock/round-robin state.
  always_comb begin
    mode_d  = mode_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    owner_d = owner_q;

    if (xfer0_s) begin
      en_d    = (addr0 != {ADDR_W{1'b0}});
      addr_d  = addr0;
      data_d  = data0;
      owner_d = 1'b0;
      last_d  = 1'b0;
    end else if (xfer1_s) begin
      en_d    = (addr1 != {ADDR_W{1'b0}});
      addr_d  = addr1;
      data_d  = data1;
      owner_d = 1'b1;
      last_d  = 1'b1;
    end else begin
      en_d = 1'b0;
    end

    case (mode_q)
      MODE_OPEN: begin
        if (xfer1_s && lock1) begin
          mode_d = MODE_LOCKED;
          cnt_d  = CNT_ONE;
        end else begin
          mode_d = MODE_OPEN;
          cnt_d  = CNT_ZERO;
        end
      end
      MODE_LOCKED: begin
        if (xfer1_s) begin
          if (lock1) begin
            mode_d = MODE_LOCKED;
            cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);
          end else begin
            mode_d = MODE_OPEN;
            cnt_d  = CNT_ZERO;
          end
        end else if (xfer0_s || !req1) begin
          // Forced release or lock abandoned by requester 1.
          mode_d = MODE_OPEN;
          cnt_d  = CNT_ZERO;
        end else begin
          mode_d = MODE_LOCKED;
          cnt_d  = cnt_q;
        end
      end
      default: begin
        mode_d = MODE_OPEN;
        cnt_d  = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_OPEN;
      last_q  <= 1'b1;
      cnt_q   <= CNT_ZERO;
      en_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      owner_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      owner_q <= owner_d;
    end
  end

  assign gnt0     = gnt0_s;
  assign gnt1     = gnt1_s;
  assign en_reg   = en_q;
  assign wr_addr  = addr_q;
  assign D_vector = data_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (MAX_BURST = 4).
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic [4:0]  addr0;
  logic [31:0] data0;
  logic        gnt0;
  logic        req1;
  logic        lock1;
  logic [4:0]  addr1;
  logic [31:0] data1;
  logic        gnt1;
  logic        en_reg;
  logic [4:0]  wr_addr;
  logic [31:0] D_vector;
  logic        owner;

  int tests_run;
  int tests_failed;

  reg_write_arbiter #(
    .WIDTH(32),
    .ADDR_W(5),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req0(req0),
    .addr0(addr0),
    .data0(data0),
    .gnt0(gnt0),
    .req1(req1),
    .lock1(lock1),
    .addr1(addr1),
    .data1(data1),
    .gnt1(gnt1),
    .en_reg(en_reg),
    .wr_addr(wr_addr),
    .D_vector(D_vector),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are set just after an edge; grants are sampled 1 time unit later.
  task automatic check_gnt(input string tag, input logic e0, input logic e1);
    #1;
    check({tag, ".gnt0"}, 32'(gnt0), 32'(e0));
    check({tag, ".gnt1"}, 32'(gnt1), 32'(e1));
  endtask

  task automatic check_out(input string tag, input logic e_en, input logic [4:0] e_addr,
                           input logic [31:0] e_data, input logic e_owner);
    check({tag, ".en_reg"},   32'(en_reg),  32'(e_en));
    check({tag, ".wr_addr"},  32'(wr_addr), 32'(e_addr));
    check({tag, ".D_vector"}, D_vector,     e_data);
    check({tag, ".owner"},    32'(owner),   32'(e_owner));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset held two cycles with both requesting.
    rst_n = 1'b0;
    req0  = 1'b1; addr0 = 5'd3; data0 = 32'hA0A0_A0A0;
    req1  = 1'b1; lock1 = 1'b0; addr1 = 5'd7; data1 = 32'hB1B1_B1B1;
    tick();
    tick();
    check_gnt("rst", 1'b0, 1'b0);
    check_out("rst", 1'b0, 5'd0, 32'h0000_0000, 1'b0);

    // Release; round-robin 0,1,0,1 with both requesting.
    rst_n = 1'b1;
    check_gnt("rr0", 1'b1, 1'b0);
    tick();
    check_out("rr0", 1'b1, 5'd3, 32'hA0A0_A0A0, 1'b0);
    check_gnt("rr1", 1'b0, 1'b1);
    tick();
    check_out("rr1", 1'b1, 5'd7, 32'hB1B1_B1B1, 1'b1);
    check_gnt("rr2", 1'b1, 1'b0);
    tick();
    check_out("rr2", 1'b1, 5'd3, 32'hA0A0_A0A0, 1'b0);
    check_gnt("rr3", 1'b0, 1'b1);
    tick();
    check_out("rr3", 1'b1, 5'd7, 32'hB1B1_B1B1, 1'b1);

    // Single write from requester 0, then idle.
    req1 = 1'b0;
    addr0 = 5'd5; data0 = 32'h0000_000F;
    check_gnt("single", 1'b1, 1'b0);
    tick();
    check_out("single", 1'b1, 5'd5, 32'h0000_000F, 1'b0);
    req0 = 1'b0;
    check_gnt("idle", 1'b0, 1'b0);
    tick();
    check_out("idle", 1'b0, 5'd5, 32'h0000_000F, 1'b0);

    // Write to x0 from requester 1: granted, no enable.
    req1 = 1'b1; addr1 = 5'd0; data1 = 32'hFFFF_FFFF;
    check_gnt("x0", 1'b0, 1'b1);
    tick();
    check_out("x0", 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1);

    // Locked burst; requester 0 raised at the 2nd transfer, forced in after 4.
    req1 = 1'b1; lock1 = 1'b1; addr1 = 5'd9; data1 = 32'h0000_0101;
    check_gnt("burst1", 1'b0, 1'b1);
    tick();
    check_out("burst1", 1'b1, 5'd9, 32'h0000_0101, 1'b1);
    req0 = 1'b1; addr0 = 5'd2; data0 = 32'h0000_0022;
    data1 = 32'h0000_0102;
    check_gnt("burst2", 1'b0, 1'b1);
    tick();
    check_out("burst2", 1'b1, 5'd9, 32'h0000_0102, 1'b1);
    data1 = 32'h0000_0103;
    check_gnt("burst3", 1'b0, 1'b1);
    tick();
    check_out("burst3", 1'b1, 5'd9, 32'h0000_0103, 1'b1);
    data1 = 32'h0000_0104;
    check_gnt("burst4", 1'b0, 1'b1);
    tick();
    check_out("burst4", 1'b1, 5'd9, 32'h0000_0104, 1'b1);
    data1 = 32'h0000_0105;
    check_gnt("forced", 1'b1, 1'b0);
    tick();
    check_out("forced", 1'b1, 5'd2, 32'h0000_0022, 1'b0);
    // Back to OPEN with last=0: tie goes to requester 1 (which relocks).
    check_gnt("tie_after_force", 1'b0, 1'b1);
    tick();
    check_out("tie_after_force", 1'b1, 5'd9, 32'h0000_0105, 1'b1);
    // Release with req0 waiting: next cycle OPEN, last=1, requester 0 wins.
    lock1 = 1'b0; data1 = 32'h0000_0106;
    check_gnt("release", 1'b0, 1'b1);
    tick();
    check_out("release", 1'b1, 5'd9, 32'h0000_0106, 1'b1);
    check_gnt("after_release", 1'b1, 1'b0);
    tick();
    check_out("after_release", 1'b1, 5'd2, 32'h0000_0022, 1'b0);

    // Reset mid-burst during the 3rd locked transfer.
    req0 = 1'b0; lock1 = 1'b1; addr1 = 5'd4; data1 = 32'h0000_0201;
    check_gnt("mid1", 1'b0, 1'b1);
    tick();
    check_out("mid1", 1'b1, 5'd4, 32'h0000_0201, 1'b1);
    data1 = 32'h0000_0202;
    check_gnt("mid2", 1'b0, 1'b1);
    tick();
    check_out("mid2", 1'b1, 5'd4, 32'h0000_0202, 1'b1);
    data1 = 32'h0000_0203;
    rst_n = 1'b0;
    check_gnt("mid_rst", 1'b0, 1'b0);
    tick();
    check_out("mid_rst", 1'b0, 5'd0, 32'h0000_0000, 1'b0);
    rst_n = 1'b1; req0 = 1'b1; lock1 = 1'b0;
    check_gnt("post_rst_tie", 1'b1, 1'b0);
    tick();
    check_out("post_rst_tie", 1'b1, 5'd2, 32'h0000_0022, 1'b0);

    // Counter saturates while requester 0 is idle; raising req0 then forces release at once.
    req0 = 1'b0; lock1 = 1'b1; addr1 = 5'd11;
    for (int i = 0; i < 6; i++) begin
      data1 = 32'h0000_0300 + 32'(i);
      check_gnt("sat", 1'b0, 1'b1);
      tick();
      check_out("sat", 1'b1, 5'd11, 32'h0000_0300 + 32'(i), 1'b1);
    end
    req0 = 1'b1;
    check_gnt("sat_force", 1'b1, 1'b0);
    tick();
    check_out("sat_force", 1'b1, 5'd2, 32'h0000_0022, 1'b0);

    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    tick();
    check_out("final_idle", 1'b0, 5'd2, 32'h0000_0022, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
